crc_stream: RTL and testbench

- Parametrised, frame-aware CRC engine for the FireWire and Ethernet packet paths.
- Accepts a word-wide data stream with first/last framing and computes a CRC of configurable width, polynomial, init value and output XOR.
- Processes one word per clock. On the last word it presents a registered result, a residue check flag and per-frame statistics.
- Default parameters give the 16-bit CRC with polynomial 0x1DB7 and init 0xFFFF, MSB-first, byte-wide.

---
 rtl/crc_stream.sv | 145 ++++++++++++++
 tb/tb_crc_stream.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream.sv
// Frame-aware streaming CRC engine, MSB-first, one word per clock.
// Registered result, residue check and frame/error statistics.
module crc_stream #(
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h1DB7,
    parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOROUT  = 16'h0000,
    parameter logic [CRC_W-1:0] RESIDUE = 16'h0000,
    parameter int               DATA_W  = 8,
    parameter int               CNT_W   = 16,
    localparam int              NBYTES  = DATA_W / 8,
    localparam int              NB_W    = $clog2(NBYTES) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s_valid,
    input  logic              s_first,
    input  logic              s_last,
    input  logic [DATA_W-1:0] s_data,
    input  logic [NB_W-1:0]   s_nbytes,
    output logic              crc_valid,
    output logic [CRC_W-1:0]  crc_out,
    output logic              check_ok,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              abort
);

    typedef enum logic {
        IDLE,
        FRAME
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_nx;
    logic [CRC_W-1:0] upd;
    logic [NB_W-1:0]  nb;
    logic             done;
    logic             ab;
    logic             err;

    // Advance the register over the first n bytes of d, MSB of each byte first.
    function automatic logic [CRC_W-1:0] crc_update(
        input logic [CRC_W-1:0] c_in,
        input logic [DATA_W-1:0] d,
        input logic [NB_W-1:0] n
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = c_in;
        for (int b = 0; b < NBYTES; b++) begin
            if (b < int'(n)) begin
                for (int j = 0; j < 8; j++) begin
                    fb = c[CRC_W-1] ^ d[DATA_W-1-8*b-j];
                    c  = {c[CRC_W-2:0], 1'b0};
                    if (fb) c = c ^ POLY;
                end
            end
        end
        return c;
    endfunction

    // Effective byte count: partial only on a last word; zero or overrange means full.
    always_comb begin
        nb = NB_W'(NBYTES);
        if (s_last && s_nbytes != '0 && int'(s_nbytes) <= NBYTES)
            nb = s_nbytes;
    end

    // Next-state, next-register and per-cycle event decode.
    always_comb begin
        state_nx = state;
        crc_nx   = crc_q;
        done     = 1'b0;
        ab       = 1'b0;
        err      = 1'b0;
        upd      = crc_update(s_first ? INIT : crc_q, s_data, nb);
        unique case (state)
            IDLE: begin
                if (s_valid) begin
                    if (s_first) begin
                        crc_nx = upd;
                        if (s_last) done = 1'b1;
                        else state_nx = FRAME;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            FRAME: begin
                if (s_valid) begin
                    crc_nx = upd;
                    if (s_first) begin
                        ab  = 1'b1;
                        err = 1'b1;
                    end
                    if (s_last) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and running CRC register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            crc_q <= INIT;
        end else begin
            state <= state_nx;
            crc_q <= crc_nx;
        end
    end

    // Registered result, pulses and statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            crc_valid <= 1'b0;
            crc_out   <= '0;
            check_ok  <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
            abort     <= 1'b0;
        end else begin
            crc_valid <= done;
            abort     <= ab;
            busy      <= (state_nx == FRAME);
            if (done) begin
                crc_out   <= upd ^ XOROUT;
                check_ok  <= (upd == RESIDUE);
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (err && err_cnt != '1)
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_crc_stream.sv
// Directed and randomised checks for crc_stream in three configurations:
// default CRC-16 byte-wide, CRC-16 16-bit words, CRC-32 32-bit words.
module tb_crc_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Default instance: CRC-16 0x1DB7, byte-wide
    logic        a_v = 0, a_f = 0, a_l = 0;
    logic [7:0]  a_d = 0;
    logic        a_nb = 0;
    logic        a_cv, a_ok, a_busy, a_ab;
    logic [15:0] a_out, a_fc, a_ec;

    crc_stream u_a (
        .clock(clk), .reset(rst),
        .s_valid(a_v), .s_first(a_f), .s_last(a_l),
        .s_data(a_d), .s_nbytes(a_nb),
        .crc_valid(a_cv), .crc_out(a_out), .check_ok(a_ok),
        .busy(a_busy), .frame_cnt(a_fc), .err_cnt(a_ec), .abort(a_ab)
    );

    // CRC-16 with 16-bit words
    logic        b_v = 0, b_f = 0, b_l = 0;
    logic [15:0] b_d = 0;
    logic [1:0]  b_nb = 0;
    logic        b_cv, b_ok, b_busy, b_ab;
    logic [15:0] b_out, b_fc, b_ec;

    crc_stream #(.DATA_W(16)) u_b (
        .clock(clk), .reset(rst),
        .s_valid(b_v), .s_first(b_f), .s_last(b_l),
        .s_data(b_d), .s_nbytes(b_nb),
        .crc_valid(b_cv), .crc_out(b_out), .check_ok(b_ok),
        .busy(b_busy), .frame_cnt(b_fc), .err_cnt(b_ec), .abort(b_ab)
    );

    // Non-reflected CRC-32 with 32-bit words
    logic        c_v = 0, c_f = 0, c_l = 0;
    logic [31:0] c_d = 0;
    logic [2:0]  c_nb = 0;
    logic        c_cv, c_ok, c_busy, c_ab;
    logic [31:0] c_out;
    logic [15:0] c_fc, c_ec;

    crc_stream #(
        .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .XOROUT(32'hFFFFFFFF), .RESIDUE(32'h00000000), .DATA_W(32)
    ) u_c (
        .clock(clk), .reset(rst),
        .s_valid(c_v), .s_first(c_f), .s_last(c_l),
        .s_data(c_d), .s_nbytes(c_nb),
        .crc_valid(c_cv), .crc_out(c_out), .check_ok(c_ok),
        .busy(c_busy), .frame_cnt(c_fc), .err_cnt(c_ec), .abort(c_ab)
    );

    // Bit-serial reference for the CRC-32 configuration
    function automatic logic [31:0] m32(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C11DB7;
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_word(input logic f, input logic l, input logic [7:0] d);
        a_v = 1; a_f = f; a_l = l; a_d = d;
        tick();
        a_v = 0; a_f = 0; a_l = 0;
    endtask

    task automatic b_word(input logic f, input logic l, input logic [15:0] d,
                          input logic [1:0] n);
        b_v = 1; b_f = f; b_l = l; b_d = d; b_nb = n;
        tick();
        b_v = 0; b_f = 0; b_l = 0;
    endtask

    task automatic c_word(input logic f, input logic l, input logic [31:0] d,
                          input logic [2:0] n);
        c_v = 1; c_f = f; c_l = l; c_d = d; c_nb = n;
        tick();
        c_v = 0; c_f = 0; c_l = 0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({a_cv, a_ok, a_busy, a_ab} !== 4'b0 || a_out !== 16'h0
            || a_fc !== 16'h0 || a_ec !== 16'h0) begin
            bad++;
            $display("FAIL reset_a: cv=%b ok=%b busy=%b ab=%b out=%h fc=%0d ec=%0d want all 0",
                     a_cv, a_ok, a_busy, a_ab, a_out, a_fc, a_ec);
        end
        total++;
        if ({b_cv, b_busy, c_cv, c_busy} !== 4'b0 || b_out !== 16'h0 || c_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_bc: b_cv=%b c_cv=%b b_out=%h c_out=%h want 0",
                     b_cv, c_cv, b_out, c_out);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_single;
        a_word(1, 1, 8'h00);
        total++;
        if (a_cv !== 1'b1 || a_out !== 16'h520C || a_ok !== 1'b0 || a_fc !== 16'd1) begin
            bad++;
            $display("FAIL single: cv=%b out=%h ok=%b fc=%0d want 1 520c 0 1",
                     a_cv, a_out, a_ok, a_fc);
        end
        tick();
        total++;
        if (a_cv !== 1'b0 || a_out !== 16'h520C || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL single_hold: cv=%b out=%h busy=%b want 0 520c 0",
                     a_cv, a_out, a_busy);
        end
    endtask

    task automatic test_residue;
        a_word(1, 0, 8'h00);
        total++;
        if (a_busy !== 1'b1 || a_cv !== 1'b0) begin
            bad++;
            $display("FAIL residue_busy: busy=%b cv=%b want 1 0", a_busy, a_cv);
        end
        a_word(0, 0, 8'h52);
        a_word(0, 1, 8'h0C);
        total++;
        if (a_cv !== 1'b1 || a_out !== 16'h0000 || a_ok !== 1'b1
            || a_fc !== 16'd2 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL residue: cv=%b out=%h ok=%b fc=%0d busy=%b want 1 0000 1 2 0",
                     a_cv, a_out, a_ok, a_fc, a_busy);
        end
        tick();
    endtask

    task automatic test_wide16;
        b_word(1, 0, 16'h0052, 2'd0);
        b_word(0, 1, 16'h0C00, 2'd1);
        total++;
        if (b_cv !== 1'b1 || b_out !== 16'h0000 || b_ok !== 1'b1 || b_fc !== 16'd1) begin
            bad++;
            $display("FAIL wide16_partial: cv=%b out=%h ok=%b fc=%0d want 1 0000 1 1",
                     b_cv, b_out, b_ok, b_fc);
        end
        b_word(1, 1, 16'h0000, 2'd0);
        total++;
        if (b_cv !== 1'b1 || b_out !== 16'hCC6C || b_ok !== 1'b0) begin
            bad++;
            $display("FAIL wide16_nb0: cv=%b out=%h ok=%b want 1 cc6c 0", b_cv, b_out, b_ok);
        end
        b_word(1, 1, 16'h00FF, 2'd1);
        total++;
        if (b_cv !== 1'b1 || b_out !== 16'h520C || b_fc !== 16'd3) begin
            bad++;
            $display("FAIL wide16_nb1: cv=%b out=%h fc=%0d want 1 520c 3", b_cv, b_out, b_fc);
        end
        tick();
    endtask

    task automatic test_errors;
        a_word(0, 0, 8'h33);
        total++;
        if (a_ec !== 16'd1 || a_cv !== 1'b0 || a_busy !== 1'b0 || a_ab !== 1'b0) begin
            bad++;
            $display("FAIL idle_err: ec=%0d cv=%b busy=%b ab=%b want 1 0 0 0",
                     a_ec, a_cv, a_busy, a_ab);
        end
        a_word(1, 0, 8'h11);
        a_word(0, 0, 8'h22);
        a_word(1, 0, 8'h00);
        total++;
        if (a_ab !== 1'b1 || a_ec !== 16'd2 || a_busy !== 1'b1) begin
            bad++;
            $display("FAIL abort: ab=%b ec=%0d busy=%b want 1 2 1", a_ab, a_ec, a_busy);
        end
        a_word(0, 0, 8'h52);
        total++;
        if (a_ab !== 1'b0 || a_ec !== 16'd2) begin
            bad++;
            $display("FAIL abort_pulse: ab=%b ec=%0d want 0 2", a_ab, a_ec);
        end
        a_word(0, 1, 8'h0C);
        total++;
        if (a_cv !== 1'b1 || a_out !== 16'h0000 || a_ok !== 1'b1 || a_fc !== 16'd3) begin
            bad++;
            $display("FAIL restart_crc: cv=%b out=%h ok=%b fc=%0d want 1 0000 1 3",
                     a_cv, a_out, a_ok, a_fc);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        a_word(1, 0, 8'h00);
        a_word(0, 0, 8'h11);
        rst = 1;
        tick();
        rst = 0;
        total++;
        if (a_busy !== 1'b0 || a_cv !== 1'b0 || a_fc !== 16'd0 || a_ec !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b cv=%b fc=%0d ec=%0d want 0 0 0 0",
                     a_busy, a_cv, a_fc, a_ec);
        end
        tick();
        total++;
        if (a_cv !== 1'b0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_stale: cv=%b busy=%b want 0 0", a_cv, a_busy);
        end
        a_word(1, 1, 8'h00);
        total++;
        if (a_cv !== 1'b1 || a_out !== 16'h520C || a_fc !== 16'd1) begin
            bad++;
            $display("FAIL after_reset: cv=%b out=%h fc=%0d want 1 520c 1", a_cv, a_out, a_fc);
        end
    endtask

    task automatic test_back_to_back;
        a_word(1, 1, 8'h00);
        total++;
        if (a_cv !== 1'b1 || a_out !== 16'h520C || a_fc !== 16'd2) begin
            bad++;
            $display("FAIL b2b_first: cv=%b out=%h fc=%0d want 1 520c 2", a_cv, a_out, a_fc);
        end
        a_word(1, 1, 8'h00);
        total++;
        if (a_cv !== 1'b1 || a_out !== 16'h520C || a_fc !== 16'd3) begin
            bad++;
            $display("FAIL b2b_second: cv=%b out=%h fc=%0d want 1 520c 3", a_cv, a_out, a_fc);
        end
        tick();
        total++;
        if (a_cv !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: cv=%b want 0", a_cv);
        end
    endtask

    task automatic test_crc32;
        c_word(1, 0, 32'h31323334, 3'd0);
        c_word(0, 0, 32'h35363738, 3'd0);
        c_word(0, 1, 32'h39AABBCC, 3'd1);
        total++;
        if (c_cv !== 1'b1 || c_out !== 32'hFC891918 || c_ok !== 1'b0 || c_fc !== 16'd1) begin
            bad++;
            $display("FAIL crc32_check: cv=%b out=%h ok=%b fc=%0d want 1 fc891918 0 1",
                     c_cv, c_out, c_ok, c_fc);
        end
        tick();
    endtask

    task automatic test_random;
        int          n;
        int          nw;
        int          idx;
        int          nb;
        int          errs;
        logic [31:0] m;
        logic [31:0] w;
        logic [7:0]  by;
        logic        lst;
        errs = 0;
        for (int f = 0; f < 1000; f++) begin
            n  = $urandom_range(1, 12);
            nw = (n + 3) / 4;
            m  = 32'hFFFFFFFF;
            for (int k = 0; k < nw; k++) begin
                w = $urandom;
                for (int j = 0; j < 4; j++) begin
                    idx = 4 * k + j;
                    if (idx < n) begin
                        by = 8'($urandom_range(0, 255));
                        w[31-8*j -: 8] = by;
                        m = m32(m, by);
                    end
                end
                lst = (k == nw - 1);
                nb  = lst ? n - 4 * k : 4;
                if (nb == 4 && $urandom_range(0, 1) == 0) nb = 0;
                c_word(k == 0, lst, w, 3'(nb));
                if (!lst && $urandom_range(0, 3) == 0) tick();
            end
            total++;
            if (c_cv !== 1'b1 || c_out !== (m ^ 32'hFFFFFFFF)) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand32 frame %0d len %0d: cv=%b out=%h want 1 %h",
                             f, n, c_cv, c_out, m ^ 32'hFFFFFFFF);
            end
        end
        tick();
        total++;
        if (c_fc !== 16'd1001 || c_ec !== 16'd0) begin
            bad++;
            $display("FAIL rand32_counts: fc=%0d ec=%0d want 1001 0", c_fc, c_ec);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_residue();
        test_wide16();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_crc32();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
